// File: rtl/abs_pkg.sv
// Shared types and constants for the magnitude frame sink.
// FSM state encoding, sample width and default frame length.
package abs_pkg;

  localparam int ABS_DW = 8;
  localparam int ABS_N  = 1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } abs_state_e;

endpackage

// File: rtl/abs_sink_ram.sv
// Simple dual-port frame buffer, one write port plus
// a registered read-first read port (block RAM style).
module abs_sink_ram
  import abs_pkg::*;
#(
  parameter int N  = ABS_N,
  parameter int DW = ABS_DW,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // output register reset maps onto the RAM's sync output reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/abs_frame_sink.sv
// Captures one frame of cal_abs magnitudes for host readout.
// Define ABS_SINK_PEAK_EN to build the peak/peak-index tracker.
module abs_frame_sink
  import abs_pkg::*;
#(
  parameter int N  = ABS_N,
  parameter int DW = ABS_DW,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          val_i,
  input  logic [DW-1:0] abs_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   cnt_o,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_val_o,
  output logic [DW-1:0] peak_o,
  output logic [AW-1:0] peak_idx_o
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(N);

  abs_state_e    state_q;
  abs_state_e    state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   cnt_q;
  logic          clr;
  logic          wr_en;
  logic          rd_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CAPTURE;
          clr     = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (val_i) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_CAPTURE;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (cnt_q != FULL) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_val_q <= 1'b0;
    end else begin
      rd_val_q <= rd_en_i;
    end
  end

  abs_sink_ram #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (abs_i),
    .rd_en   (rd_en_i),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data_o)
  );

`ifdef ABS_SINK_PEAK_EN
  logic [DW-1:0] peak_q;
  logic [AW-1:0] peak_idx_q;

  // strict compare keeps the earliest index on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else if (clr) begin
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else if (wr_en && (abs_i > peak_q)) begin
      peak_q     <= abs_i;
      peak_idx_q <= wr_ptr_q;
    end
  end

  assign peak_o     = peak_q;
  assign peak_idx_o = peak_idx_q;
`else
  assign peak_o     = '0;
  assign peak_idx_o = '0;
`endif

  assign busy_o   = (state_q == S_CAPTURE);
  assign done_o   = (state_q == S_DONE);
  assign cnt_o    = cnt_q;
  assign rd_val_o = rd_val_q;

endmodule

// File: doc/abs_frame_sink.md
# abs_frame_sink

Captures one frame of magnitude samples from the `cal_abs` output stream (`val_o`/`abs_o`) into an on-chip buffer. The frame is then available to a host through a registered random-access read port. This is the consumer end of the magnitude stream, placed directly downstream of `cal_abs`. It optionally tracks the frame's peak magnitude and the index of that peak.

## Interface
Parameters:
- `N`, 1024: samples per frame.
- `DW`, 8: magnitude width (matches `abs_o`).
- `AW`, `$clog2(N)` = 10: address width.

Ports (clock and reset first):
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: arm capture of a new frame.
- `val_i`, in, 1: sample valid. Connects to `cal_abs.val_o`.
- `abs_i`, in, DW: magnitude sample. Connects to `cal_abs.abs_o`.
- `busy_o`, out, 1: capture in progress.
- `done_o`, out, 1: full frame captured. Level signal, held until the next start.
- `cnt_o`, out, AW+1: samples captured in the current frame, range 0..N.
- `rd_en_i`, in, 1: read request.
- `rd_addr_i`, in, AW: read address.
- `rd_data_o`, out, DW: read data.
- `rd_val_o`, out, 1: read data valid.
- `peak_o`, out, DW: maximum magnitude in the frame.
- `peak_idx_o`, out, AW: index of the first occurrence of `peak_o`.

## Operation
- FSM has three states:
  - IDLE: `val_i` is ignored.
  - CAPTURE: each cycle with `val_i`=1 writes `abs_i` to `mem[wr_ptr]`, then increments `wr_ptr` and `cnt_o`.
  - DONE: holds the frame; `val_i` is ignored.
- State transitions:
  - IDLE, `start_i` → CAPTURE. Clears `wr_ptr`, `cnt_o`, peak and peak index.
  - CAPTURE, write to index N-1 → DONE.
  - CAPTURE, `start_i` → ignored; the capture continues.
  - DONE, `start_i` → CAPTURE, with the same clears as from IDLE.
- No backpressure. Every valid sample in CAPTURE is accepted; the upstream block cannot be stalled.
- Read port:
  - Usable in every state.
  - Read-first: reading the address being written in the same cycle returns the old contents.
  - Reading an unwritten address returns stale data. This is not an error.
- Peak tracking:
  - On each accepted sample, if `abs_i` > `peak_o` (strictly greater), update `peak_o` and set `peak_idx_o` = `wr_ptr`.
  - Ties keep the earliest index.
- Widths:
  - `wr_ptr` is AW bits and wraps to 0 after N-1. The wrap is unreachable because the FSM leaves CAPTURE first.
  - `cnt_o` saturates at N.
- Reset values, all outputs 0: `busy_o`, `done_o`, `cnt_o`, `rd_data_o`, `rd_val_o`, `peak_o`, `peak_idx_o`. State returns to IDLE.
- Buffer memory is not reset.

## Timing
- `start_i` sampled at edge t: `busy_o`=1 from t+1. The first sample can be accepted at edge t+1.
- Sample N-1 accepted at edge c: `busy_o`=0, `done_o`=1 and `cnt_o`=N from c+1.
- Restart from DONE with `start_i` at edge t: `done_o`=0 and `cnt_o`=0 from t+1.
- Read: `rd_en_i` at edge t gives `rd_data_o` and `rd_val_o` at t+1. `rd_val_o` is a single-cycle pulse per request. Back-to-back reads are allowed every cycle.
- Peak and count are updated one cycle after the accepted sample.
- Reset during CAPTURE:
  - The next cycle is IDLE with all outputs 0.
  - The partial frame is abandoned; memory contents are undefined for the frame.
  - A read pending in the reset cycle is dropped (`rd_val_o`=0).

## Configuration
- `ABS_SINK_PEAK_EN` defined: the peak comparator and registers are built, behaving as described in Operation.
- Not defined: `peak_o` and `peak_idx_o` are tied to 0 and no comparator logic is built. The ports remain so the interface does not change.

## Structure
- Shared package `abs_pkg` holds:
  - the FSM state typedef (IDLE/CAPTURE/DONE);
  - magnitude width constant `ABS_DW` = 8;
  - default frame length `ABS_N` = 1024.
- One sub-module, `abs_sink_ram`:
  - simple dual-port N×DW;
  - one write port, one registered read-first read port;
  - infers block RAM.
- The top level holds the FSM, counters, peak logic and read-valid register.

## Test plan
1. Full capture:
   - Stimulus: reset, `start_i` pulse, then 1024 consecutive valid samples with `abs_i` = index[7:0].
   - Response: `done_o`=1 exactly one cycle after the 1024th sample and `cnt_o`=1024. Reading addr 300 returns 0x2C one cycle later with `rd_val_o`=1.
2. Gapped input:
   - Stimulus: `val_i` high every third cycle.
   - Response: `done_o` asserts only after the 1024th valid sample. Every address reads back its sample.
3. Idle discard:
   - Stimulus: 50 samples of 0xAA with `val_i`=1 before `start_i`.
   - Response: `cnt_o` stays 0 and `busy_o` stays 0. After start, the capture begins at addr 0.
4. Peak with ties (`ABS_SINK_PEAK_EN` set):
   - Stimulus: 0xF0 at indices 17 and 900, all other samples ≤ 0xEF.
   - Response: `peak_o`=0xF0, `peak_idx_o`=17. Without the macro, both read 0.
5. Reset mid-capture:
   - Stimulus: `rst` asserted after 500 samples.
   - Response: next cycle `busy_o`, `done_o`, `cnt_o` and `peak_o` are all 0. A new start then captures a full 1024-sample frame correctly.
6. Start handling:
   - Stimulus: `start_i` at sample 200 during CAPTURE.
   - Response: ignored; `cnt_o` continues to 1024.
   - Stimulus: `start_i` in DONE.
   - Response: `done_o`=0 and `cnt_o`=0 next cycle, and a new capture proceeds.
